// File: rtl/jpeg_quant_pipe.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_quant_pipe
// Description : Three-stage, multi-lane JPEG coefficient quantiser. Each lane
//               multiplies a signed DCT coefficient by an unsigned fixed-point
//               reciprocal (rec / 2^SHIFT), rounds (half away from zero or
//               truncate toward zero, chosen per word) and saturates to OUT_W.
//               Carries a per-block word counter with end-of-block marker and
//               a sticky saturation flag.
// Ports       : clk_i, rst_i (async, active-high)
//               in_valid_i / in_ready_o / x_i / rec_i / mode_i : input side
//               out_valid_o / out_ready_i / q_o / last_o      : output side
//               clr_i : sync clear of sat_o and block counter
//               sat_o : sticky saturation indicator
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_quant_pipe #(
  parameter int LANES    = 2,
  parameter int DATA_W   = 16,
  parameter int REC_W    = 16,
  parameter int SHIFT    = 14,
  parameter int OUT_W    = 12,
  parameter int BLK_SIZE = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [LANES*DATA_W-1:0]   x_i,
  input  logic [LANES*REC_W-1:0]    rec_i,
  input  logic                      mode_i,
  input  logic                      clr_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [LANES*OUT_W-1:0]    q_o,
  output logic                      last_o,
  output logic                      sat_o
);

  localparam int c_PROD_W = DATA_W + REC_W + 1;
  localparam int c_MAG_W  = c_PROD_W + 1;
  localparam int c_WORDS  = BLK_SIZE / LANES;
  localparam int c_CNT_W  = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
  localparam logic [c_CNT_W-1:0] c_TERM    = c_CNT_W'(c_WORDS - 1);
  localparam logic [c_MAG_W-1:0] c_HALF    = c_MAG_W'(1) << (SHIFT - 1);
  localparam logic [c_MAG_W-1:0] c_LIM_POS = (c_MAG_W'(1) << (OUT_W - 1)) - c_MAG_W'(1);
  localparam logic [c_MAG_W-1:0] c_LIM_NEG = c_MAG_W'(1) << (OUT_W - 1);
  localparam logic [OUT_W-1:0]   c_Q_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]   c_Q_MIN   = {1'b1, {(OUT_W-1){1'b0}}};

  // Stage registers
  logic                        r_s1_valid, r_s1_mode, r_s1_last;
  logic [LANES*DATA_W-1:0]     r_s1_x;
  logic [LANES*REC_W-1:0]      r_s1_rec;
  logic                        r_s2_valid, r_s2_mode, r_s2_last;
  logic [LANES*c_PROD_W-1:0]   r_s2_p;
  logic                        r_out_valid, r_last, r_sat;
  logic [LANES*OUT_W-1:0]      r_q;
  logic [c_CNT_W-1:0]          r_cnt;

  logic                        w_s3_load, w_s1_adv, w_in_ready, w_accept;
  logic [c_CNT_W-1:0]          w_idx;
  logic                        w_term, w_sat_evt;
  logic [LANES*c_PROD_W-1:0]   w_prod;
  logic [LANES*OUT_W-1:0]      w_q;
  logic [LANES-1:0]            w_clip;

  // Each stage moves forward whenever the stage after it is empty or moving,
  // so bubbles collapse and a full pipe streams one word per cycle.
  assign w_s3_load  = !r_out_valid || out_ready_i;
  assign w_s1_adv   = !r_s2_valid || w_s3_load;
  assign w_in_ready = !r_s1_valid || w_s1_adv;
  assign w_accept   = in_valid_i && w_in_ready;

  // A clear coincident with an accept gives that word index 0.
  assign w_idx     = clr_i ? '0 : r_cnt;
  assign w_term    = (w_idx == c_TERM);
  assign w_sat_evt = w_s3_load && r_s2_valid && (|w_clip);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [c_PROD_W-1:0] w_xe, w_re, w_p;
    logic                       w_neg;
    logic [c_MAG_W-1:0]         w_mag, w_sum, w_r;

    // Reciprocal is zero-extended so the multiply stays signed throughout.
    assign w_xe = c_PROD_W'($signed(r_s1_x[l*DATA_W +: DATA_W]));
    assign w_re = c_PROD_W'({1'b0, r_s1_rec[l*REC_W +: REC_W]});
    assign w_prod[l*c_PROD_W +: c_PROD_W] = w_xe * w_re;

    // Round on magnitude so both modes are symmetric about zero.
    assign w_p   = r_s2_p[l*c_PROD_W +: c_PROD_W];
    assign w_neg = w_p[c_PROD_W-1];
    assign w_mag = w_neg ? (c_MAG_W'(0) - c_MAG_W'(w_p)) : c_MAG_W'(w_p);
    assign w_sum = w_mag + (r_s2_mode ? c_MAG_W'(0) : c_HALF);
    assign w_r   = w_sum >> SHIFT;

    assign w_clip[l] = w_neg ? (w_r > c_LIM_NEG) : (w_r > c_LIM_POS);
    assign w_q[l*OUT_W +: OUT_W] =
        w_clip[l] ? (w_neg ? c_Q_MIN : c_Q_MAX)
                  : (w_neg ? (OUT_W'(0) - w_r[OUT_W-1:0]) : w_r[OUT_W-1:0]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_x     <= '0;
      r_s1_rec   <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid_i;
      if (in_valid_i) begin
        r_s1_x    <= x_i;
        r_s1_rec  <= rec_i;
        r_s1_mode <= mode_i;
        r_s1_last <= w_term;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s2_valid <= 1'b0;
      r_s2_mode  <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_p     <= '0;
    end else if (w_s1_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_p    <= w_prod;
        r_s2_mode <= r_s1_mode;
        r_s2_last <= r_s1_last;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
      r_q         <= '0;
    end else if (w_s3_load) begin
      r_out_valid <= r_s2_valid;
      r_last      <= r_s2_valid && r_s2_last;
      if (r_s2_valid) begin
        r_q <= w_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_term ? '0 : w_idx + c_CNT_W'(1);
    end else if (clr_i) begin
      r_cnt <= '0;
    end
  end

  // Set has priority over clear so a saturation in the clearing cycle is kept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sat <= 1'b0;
    end else if (w_sat_evt) begin
      r_sat <= 1'b1;
    end else if (clr_i) begin
      r_sat <= 1'b0;
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = r_out_valid;
  assign q_o         = r_q;
  assign last_o      = r_last;
  assign sat_o       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_quant_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_jpeg_quant_pipe
// Description : Self-checking bench for jpeg_quant_pipe (default parameters)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_quant_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, clr, out_ready, mode;
  logic [31:0] x, rec;
  logic        in_ready, out_valid, last, sat;
  logic [23:0] q;

  jpeg_quant_pipe dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .x_i        (x),
    .rec_i      (rec),
    .mode_i     (mode),
    .clr_i      (clr),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .q_o        (q),
    .last_o     (last),
    .sat_o      (sat)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {int q0; int q1; bit last;} exp_t;
  exp_t exp_q[$];
  int   log_q0[$];
  int   log_q1[$];
  bit   log_last[$];
  int   acc_cnt = 0;
  int   mdl_cnt = 0;

  function automatic int quant(input int xv, input int rv, input bit m);
    longint p, mag, r, v;
    p   = longint'(xv) * longint'(rv);
    mag = (p < 0) ? -p : p;
    r   = m ? (mag >> 14) : ((mag + 64'sd8192) >> 14);
    v   = (p < 0) ? -r : r;
    if (v > 2047)  v = 2047;
    if (v < -2048) v = -2048;
    return int'(v);
  endfunction

  // Scoreboard: inputs are stable at the falling edge, so handshakes seen
  // here are exactly the ones that complete on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    exp_t o;
    int   idx;
    if (rst) begin
      exp_q.delete();
      mdl_cnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        log_q0.push_back($signed(q[11:0]));
        log_q1.push_back($signed(q[23:12]));
        log_last.push_back(last);
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          o = exp_q.pop_front();
          chk("sb_q0", $signed(q[11:0]), o.q0);
          chk("sb_q1", $signed(q[23:12]), o.q1);
          chk("sb_last", int'(last), int'(o.last));
        end
      end
      if (in_valid && in_ready) begin
        idx     = clr ? 0 : mdl_cnt;
        e.last  = (idx == 31);
        mdl_cnt = e.last ? 0 : idx + 1;
        e.q0    = quant($signed(x[15:0]), int'(rec[15:0]), mode);
        e.q1    = quant($signed(x[31:16]), int'(rec[31:16]), mode);
        exp_q.push_back(e);
        acc_cnt++;
      end else if (clr) begin
        mdl_cnt = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int x0, input int x1, input int r0, input int r1,
                      input bit m, input bit c);
    bit acc;
    int g;
    x        = {16'(x1), 16'(x0)};
    rec      = {16'(r1), 16'(r0)};
    mode     = m;
    clr      = c;
    in_valid = 1'b1;
    g        = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      g++;
    end while (!acc && g < 200);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 60) begin
      cyc(1);
      g++;
    end
    if (g >= 60) chk("drain_timeout", 0, 1);
  endtask

  task automatic clear_log();
    log_q0.delete();
    log_q1.delete();
    log_last.delete();
    acc_cnt = 0;
  endtask

  task automatic check_lasts(input string tag, input int n_words, input int exp_n,
                             input int p0, input int p1);
    int n, f0, f1;
    n = 0; f0 = -1; f1 = -1;
    foreach (log_last[i]) begin
      if (log_last[i]) begin
        if (n == 0) f0 = i;
        if (n == 1) f1 = i;
        n++;
      end
    end
    chk({tag, "_words"}, log_last.size(), n_words);
    chk({tag, "_nlast"}, n, exp_n);
    chk({tag, "_pos0"}, f0, p0);
    if (exp_n > 1) chk({tag, "_pos1"}, f1, p1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  done;
    int  e0[4];
    int  e1[4];
    e0 = '{1, 0, 1, 0};
    e1 = '{-1, 0, -1, 0};

    rst = 1'b1; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1; mode = 1'b0;
    x = '0; rec = '0;
    cyc(2);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    cyc(1);

    // 1: basic latency and rounding
    clear_log();
    x = {16'(-100), 16'(100)}; rec = {16'(1024), 16'(1024)}; mode = 1'b0;
    in_valid = 1'b1;
    lat = 0;
    cyc(1); lat++;
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      cyc(1);
      lat++;
    end
    chk("t1_latency", lat, 3);
    chk("t1_q0", $signed(q[11:0]), 6);
    chk("t1_q1", $signed(q[23:12]), -6);
    chk("t1_sat", int'(sat), 0);
    drain();

    // 2: rounding modes interleaved per word
    clear_log();
    for (int k = 0; k < 4; k++) send(1, -1, 8192, 8192, k[0], 1'b0);
    drain();
    chk("t2_words", log_q0.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_q0", (k < log_q0.size()) ? log_q0[k] : 9999, e0[k]);
      chk("t2_q1", (k < log_q1.size()) ? log_q1[k] : 9999, e1[k]);
    end

    // 3: saturation, sticky flag, set-wins-over-clear
    clear_log();
    send(32767, -32768, 65535, 65535, 1'b0, 1'b0);
    drain();
    chk("t3_q0", (log_q0.size() > 0) ? log_q0[0] : 9999, 2047);
    chk("t3_q1", (log_q1.size() > 0) ? log_q1[0] : 9999, -2048);
    chk("t3_sat", int'(sat), 1);
    cyc(2);
    chk("t3_sat_sticky", int'(sat), 1);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("t3_sat_clr", int'(sat), 0);
    send(32767, 0, 65535, 0, 1'b0, 1'b0);
    cyc(1);
    chk("t3_sat_before", int'(sat), 0);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("t3_set_wins", int'(sat), 1);
    drain();

    // 4: block counter and end-of-block marker
    clr = 1'b1; cyc(1); clr = 1'b0;
    clear_log();
    for (int k = 0; k < 64; k++) send(k, k, 16384, 16384, 1'b1, 1'b0);
    drain();
    check_lasts("t4_blk", 64, 2, 31, 63);
    clear_log();
    for (int k = 0; k < 10; k++) send(k, 0, 16384, 0, 1'b1, 1'b0);
    send(100, 0, 16384, 0, 1'b1, 1'b1);
    for (int k = 0; k < 40; k++) send(k, 0, 16384, 0, 1'b1, 1'b0);
    drain();
    check_lasts("t4_clr", 51, 1, 41, -1);

    // 5a: backpressure fills three stages then stalls input
    clear_log();
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) send(10 + k, 20 + k, 16384, 16384, 1'b1, 1'b0);
      end
      begin
        cyc(4);
        chk("t5_q0_early", $signed(q[11:0]), 10);
        cyc(2);
        chk("t5_accepts", acc_cnt, 3);
        chk("t5_in_ready", int'(in_ready), 0);
        chk("t5_out_valid", int'(out_valid), 1);
        chk("t5_q0_hold", $signed(q[11:0]), 10);
        chk("t5_q1_hold", $signed(q[23:12]), 20);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t5_words", log_q0.size(), 8);
    for (int k = 0; k < 8; k++)
      chk("t5_order", (k < log_q0.size()) ? log_q0[k] : 9999, 10 + k);

    // 5b: random valid/ready against the scoreboard
    clear_log();
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          if ($urandom_range(0, 3) == 0) cyc(1);
          send(int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768,
               ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 65535)),
               int'($urandom_range(0, 65535)),
               1'($urandom_range(0, 1)), 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          cyc(1);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t5_rand_words", log_q0.size(), 40);

    // 6: asynchronous reset with words in flight
    clr = 1'b1; cyc(1); clr = 1'b0;
    send(32767, 0, 65535, 0, 1'b0, 1'b0);
    send(1, 1, 16384, 16384, 1'b1, 1'b0);
    send(2, 2, 16384, 16384, 1'b1, 1'b0);
    chk("t6_sat_pre", int'(sat), 1);
    chk("t6_valid_pre", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_out_valid", int'(out_valid), 0);
    chk("t6_sat", int'(sat), 0);
    chk("t6_q", int'(q), 0);
    chk("t6_in_ready", int'(in_ready), 1);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    clear_log();
    for (int k = 0; k < 32; k++) send(k, 0, 16384, 0, 1'b1, 1'b0);
    drain();
    check_lasts("t6_blk", 32, 1, 31, -1);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
